// File: rtl/aes128_decrypt_core.sv
// Purpose : iterative AES-128 inverse cipher, byte-serial key+ciphertext in, byte-serial plaintext out.
// Latency : edge accepting byte 31 = edge 0; dout_valid rises at edge 21 (10 expand + 1 init + 10 rounds).
// Backpressure: din_ready only in LOAD; dout_ready=0 stalls OUT indefinitely with dout held stable.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   din/din_valid/din_ready      16 key bytes then 16 ciphertext bytes, FIPS byte 0 first
//   dout/dout_valid/dout_ready   16 plaintext bytes, FIPS byte 0 first
//   busy            high while expanding the key, whitening and running rounds
module aes128_decrypt_core (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic [7:0] dout,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic       busy
);

    // IDLE is only held during reset, so din_ready comes up one edge after release.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EXPAND,
        ST_INIT,
        ST_ROUND,
        ST_OUT
    } fsm_t;

    fsm_t         fsm_state;
    fsm_t         fsm_next;
    logic [4:0]   byte_cnt;   // load index 0..31, reused as output index 0..15
    logic [3:0]   rnd;        // EXPAND: step 0..9 ; ROUND: r = 9..0
    logic [127:0] key_reg;
    logic [127:0] data_reg;

    // ------------------------------------------------------------------
    // GF(2^8) arithmetic, polynomial x^8+x^4+x^3+x+1 (0x11b)
    // ------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 == a^-1 for a != 0, and 0 maps to 0 without a special case.
    // Addition chain: 2,3,6,12,15,30,60,120,126,252,254.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x126, x252;
        x2   = gf_mul(a, a);
        x3   = gf_mul(x2, a);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x126 = gf_mul(x120, x6);
        x252 = gf_mul(x126, x126);
        return gf_mul(x252, x2);
    endfunction

    // Forward S-box: inversion followed by the affine map (rotations 0..4, constant 63).
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] t;
        t = gf_inv(a);
        return t ^ {t[6:0], t[7]} ^ {t[5:0], t[7:6]} ^ {t[4:0], t[7:5]}
                 ^ {t[3:0], t[7:4]} ^ 8'h63;
    endfunction

    // Inverse S-box: inverse affine map (rotations 1,3,6, constant 05) then inversion.
    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] t;
        t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Round constant for key-schedule step i (1..10).
    function automatic logic [7:0] rcon_lut(input logic [3:0] i);
        logic [7:0] r;
        case (i)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Byte b of the 128-bit block (b = 4*column + row) lives at bits [8*(15-b) +: 8].
    // Row r is rotated right by r columns.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[8*(15-(4*c+r)) +: 8] = s[8*(15-(4*((c+4-r)%4)+r)) +: 8];
            end
        end
        return o;
    endfunction

    // One column of InvMixColumns; multiples of 9/b/d/e built from an xtime chain.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[8*(3-i) +: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // ------------------------------------------------------------------
    // Key schedule: one shared set of 4 S-boxes serves both directions.
    // Forward, the S-box word is w3. Rewinding, the old w3 is recovered
    // as n3^n2 before it can be pushed through the S-boxes.
    // ------------------------------------------------------------------
    logic [31:0]  sw_in;
    logic [7:0]   rcon;
    logic [31:0]  ks_tmp;
    logic [31:0]  f0, f1, f2, f3;
    logic [127:0] key_fwd;
    logic [127:0] key_inv;

    always_comb begin
        sw_in   = (fsm_state == ST_ROUND) ? (key_reg[31:0] ^ key_reg[63:32]) : key_reg[31:0];
        rcon    = rcon_lut(rnd + 4'd1);
        ks_tmp  = sub_word({sw_in[23:0], sw_in[31:24]}) ^ {rcon, 24'h000000};
        f0      = key_reg[127:96] ^ ks_tmp;
        f1      = key_reg[95:64]  ^ f0;
        f2      = key_reg[63:32]  ^ f1;
        f3      = key_reg[31:0]   ^ f2;
        key_fwd = {f0, f1, f2, f3};
        key_inv = {key_reg[127:96] ^ ks_tmp,
                   key_reg[95:64]  ^ key_reg[127:96],
                   key_reg[63:32]  ^ key_reg[95:64],
                   key_reg[31:0]   ^ key_reg[63:32]};
    end

    // ------------------------------------------------------------------
    // Inverse round datapath: 16 inverse S-boxes, key add with the
    // freshly rewound round key, InvMixColumns skipped on the last round.
    // ------------------------------------------------------------------
    logic [127:0] isr;
    logic [127:0] isb;
    logic [127:0] ark;
    logic [127:0] imc;
    logic [127:0] round_out;

    always_comb begin
        isr = inv_shift_rows(data_reg);
        isb = '0;
        imc = '0;
        for (int b = 0; b < 16; b++) begin
            isb[8*b +: 8] = inv_sbox(isr[8*b +: 8]);
        end
        ark = isb ^ key_inv;
        for (int c = 0; c < 4; c++) begin
            imc[32*c +: 32] = inv_mix_col(ark[32*c +: 32]);
        end
        round_out = (rnd == 4'd0) ? ark : imc;
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) fsm_state <= ST_IDLE;
        else     fsm_state <= fsm_next;
    end

    always_comb begin
        fsm_next   = fsm_state;
        din_ready  = 1'b0;
        dout_valid = 1'b0;
        dout       = 8'h00;
        busy       = 1'b0;
        case (fsm_state)
            ST_IDLE: fsm_next = ST_LOAD;
            ST_LOAD: begin
                din_ready = 1'b1;
                if (din_valid && byte_cnt == 5'd31) fsm_next = ST_EXPAND;
            end
            ST_EXPAND: begin
                busy = 1'b1;
                if (rnd == 4'd9) fsm_next = ST_INIT;
            end
            ST_INIT: begin
                busy     = 1'b1;
                fsm_next = ST_ROUND;
            end
            ST_ROUND: begin
                busy = 1'b1;
                if (rnd == 4'd0) fsm_next = ST_OUT;
            end
            ST_OUT: begin
                dout_valid = 1'b1;
                // {~idx,3'b0} == 8*(15-idx): byte 0 sits in the top byte lane
                dout       = data_reg[{~byte_cnt[3:0], 3'b000} +: 8];
                if (dout_ready && byte_cnt[3:0] == 4'd15) fsm_next = ST_LOAD;
            end
            default: fsm_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_reg  <= '0;
            data_reg <= '0;
            byte_cnt <= '0;
            rnd      <= '0;
        end else begin
            case (fsm_state)
                ST_LOAD: begin
                    if (din_valid) begin
                        // byte_cnt wraps 31 -> 0, ready for the output phase
                        byte_cnt <= byte_cnt + 5'd1;
                        if (byte_cnt[4]) data_reg <= {data_reg[119:0], din};
                        else             key_reg  <= {key_reg[119:0], din};
                    end
                    rnd <= 4'd0;
                end
                ST_EXPAND: begin
                    key_reg <= key_fwd;
                    rnd     <= rnd + 4'd1;
                end
                ST_INIT: begin
                    data_reg <= data_reg ^ key_reg;
                    rnd      <= 4'd9;
                end
                ST_ROUND: begin
                    key_reg  <= key_inv;
                    data_reg <= round_out;
                    if (rnd != 4'd0) rnd <= rnd - 4'd1;
                end
                ST_OUT: begin
                    if (dout_ready) begin
                        if (byte_cnt[3:0] == 4'd15) begin
                            byte_cnt <= '0;
                            rnd      <= '0;
                        end else begin
                            byte_cnt <= byte_cnt + 5'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/aes128_decrypt_core.md
Name: aes128_decrypt_core

Overview:
- Iterative AES-128 inverse cipher (FIPS-197); the decryption counterpart to the team's AES-128 encrypt block.
- Takes the original 128-bit cipher key and a 128-bit ciphertext over a byte-serial valid/ready input stream.
- Derives the round-10 key on chip, runs 10 inverse rounds while rewinding the key schedule, and streams the 16-byte plaintext out over a valid/ready output.
- Instantiated inside the tt_um top, behind the ui_in/uio pin mapping.

Parameters:
- None. AES-128 only: Nk=4, Nr=10.

Ports:
- clk        input   1  system clock, rising edge
- rst        input   1  asynchronous reset, active-high
- din        input   8  input byte
- din_valid  input   1  din is presented this cycle
- din_ready  output  1  core accepts a byte this cycle
- dout       output  8  plaintext byte
- dout_valid output  1  dout holds a valid byte
- dout_ready input   1  sink accepts dout this cycle
- busy       output  1  high in EXPAND, INIT and ROUND

Behaviour:
- Interface: one clock (clk); asynchronous active-high reset (rst). All state clears immediately on rst=1.
- Reset values: din_ready=0 while rst is asserted, then 1 from the first edge after release (state LOAD). dout=8'h00, dout_valid=0, busy=0. Byte counter, round counter, key and state registers all 0.
- Transfer rules:
  - A byte transfers on any rising edge with din_valid&din_ready.
  - Output byte transfers on any rising edge with dout_valid&dout_ready.
  - din_valid is ignored when din_ready=0; no buffering of dropped bytes.
- Byte order: bytes are sent MSB-first (FIPS byte 0 first).
  - Transfers 0-15 are the cipher key.
  - Transfers 16-31 are the ciphertext.
  - 5-bit load counter; no gaps required, and stalls (din_valid=0) are allowed anywhere.
- State machine:
  - LOAD: din_ready=1. Accepting byte 31 moves to EXPAND with rcon=01 and the round counter at 0.
  - EXPAND: 10 cycles. Each cycle applies one forward key-schedule step (RotWord, SubWord, rcon) to the key register. Rcon sequence: 01,02,04,08,10,20,40,80,1b,36. After 10 cycles the register holds rk10; go to INIT.
  - INIT: 1 cycle. state <= ct ^ rk10; go to ROUND with r=9.
  - ROUND: 10 cycles, r=9 down to 0. Each cycle:
    - key <= rk_r, computed by the inverse key-schedule step from rk_{r+1} using rcon[r+1].
    - state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk_r).
    - InvMixColumns is omitted when r=0.
    - After r=0, go to OUT.
  - OUT: dout_valid=1; dout = plaintext byte indexed by the output counter, MSB first. After the 16th output transfer: dout_valid=0, counters clear, return to LOAD.
- Latency: the edge that accepts byte 31 is edge 0. dout_valid rises at edge 21 (10+1+10) and stays high until the 16th byte is taken. dout_ready=0 stalls OUT indefinitely; dout holds stable while stalled.
- S-boxes:
  - 4 forward S-boxes for the key schedule and 16 inverse S-boxes for the datapath.
  - Implemented as GF(2^8) inversion (poly 11b) plus affine or inverse-affine maps.
  - Inverse of 00 is 00: Sbox(00)=63, InvSbox(63)=00.
- InvMixColumns uses fixed coefficients 0e,0b,0d,09 via xtime chains.
- Edge cases:
  - Reset mid-load or mid-round discards everything; the next operation starts from key byte 0.
  - din_valid held high through EXPAND, ROUND and OUT has no effect.
  - Back-to-back operations: din_ready rises on the cycle after the 16th output transfer.

Test Plan:
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> pt 00112233445566778899aabbccddeeff. dout_valid at edge 21 after byte 31. Internal key equals 13111d7fe3944a17f307a78b4d2b30c5 at INIT.
- FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> pt 3243f6a8885a308d313198a2e0370734. Run with random din_valid gaps and random dout_ready stalls; output unchanged, dout stable during stalls.
- Busy/handshake: drive din_valid=1 with garbage during EXPAND/ROUND/OUT -> din_ready=0, busy=1 for exactly 21 cycles, and the result still matches C.1.
- Reset mid-operation: assert rst at ROUND r=5 -> outputs return to reset values immediately. Then a full C.1 load -> correct pt.
- Back-to-back: C.1 then B with no idle cycles -> both plaintexts correct. din_ready rises exactly one cycle after the 16th output transfer of the first run.
- Zero vector: key 00..00, ct 66e94bd4ef8a2c3b884cfa59ca342b2e -> pt 00000000000000000000000000000000.
